// File: rtl/n2t_pkg.sv
// Shared Hack (nand2tetris) definitions: jump-field encodings and the
// default program-counter / ROM address width used by the ROM and CPU top.
package n2t_pkg;

    // Hack ROM holds 32K words, so the PC is 15 bits wide.
    localparam int PC_WIDTH = 15;

    // Jump field {j1,j2,j3}: j1 = out<0, j2 = out==0, j3 = out>0.
    typedef enum logic [2:0] {
        JNULL = 3'b000,
        JGT   = 3'b001,
        JEQ   = 3'b010,
        JGE   = 3'b011,
        JLT   = 3'b100,
        JNE   = 3'b101,
        JLE   = 3'b110,
        JMP   = 3'b111
    } jump_e;

    // Bit positions of the individual jump bits inside the field.
    localparam int J1_LT = 2;
    localparam int J2_EQ = 1;
    localparam int J3_GT = 0;

endpackage

// File: rtl/jump_cond_n2t.sv
// Combinational jump predicate built from the gate primitives:
// jump = is_c_instr & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr)).
// The illegal zr=1/ng=1 combination simply follows the same gates, so no X
// can be produced for any fully-known input.
module jump_cond_n2t
    import n2t_pkg::*;
(
    input  logic       is_c_instr,
    input  logic [2:0] jbits,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);

    logic not_ng;
    logic not_zr;
    logic positive;
    logic lt_hit;
    logic eq_hit;
    logic gt_hit;
    logic lt_or_eq;
    logic any_hit;

    // out > 0 is "neither negative nor zero".
    not_n2t u_not_ng (.a(ng), .y(not_ng));
    not_n2t u_not_zr (.a(zr), .y(not_zr));
    and_n2t u_pos    (.a(not_ng), .b(not_zr), .y(positive));

    // Each jump bit is qualified by the ALU condition it selects.
    and_n2t u_lt (.a(jbits[J1_LT]), .b(ng),       .y(lt_hit));
    and_n2t u_eq (.a(jbits[J2_EQ]), .b(zr),       .y(eq_hit));
    and_n2t u_gt (.a(jbits[J3_GT]), .b(positive), .y(gt_hit));

    // Any selected condition met, gated by the instruction type so that
    // A-instructions can never branch.
    or_n2t  u_or1  (.a(lt_hit),   .b(eq_hit), .y(lt_or_eq));
    or_n2t  u_or2  (.a(lt_or_eq), .b(gt_hit), .y(any_hit));
    and_n2t u_cins (.a(is_c_instr), .b(any_hit), .y(jump));

endmodule

// File: rtl/n2t_gates.sv
// Gate-level primitives of the nand2tetris flow. They are kept as separate
// modules so that derived logic keeps the same structure as the gate netlist.

module not_n2t (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module and_n2t (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module or_n2t (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/pc_jump_n2t.sv
// Hack program counter with integrated jump evaluation. Loads the A-register
// target on a taken jump, otherwise increments (wrapping). Also reports taken
// jumps one cycle later and keeps a saturating count of them.
module pc_jump_n2t
    import n2t_pkg::*;
#(
    parameter int                WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 is_c_instr,
    input  logic [2:0]           jbits,
    input  logic                 zr,
    input  logic                 ng,
    input  logic [WIDTH-1:0]     a_in,
    output logic [WIDTH-1:0]     pc,
    output logic                 jump_taken,
    output logic [CNT_WIDTH-1:0] jump_count
);

    logic                 jump;
    logic [WIDTH-1:0]     pc_inc;
    logic [WIDTH-1:0]     pc_next;
    logic                 taken_next;
    logic [CNT_WIDTH-1:0] count_next;

    jump_cond_n2t u_jump_cond (
        .is_c_instr (is_c_instr),
        .jbits      (jbits),
        .zr         (zr),
        .ng         (ng),
        .jump       (jump)
    );

    // Incrementer wraps naturally modulo 2^WIDTH; no overflow flag is needed.
    assign pc_inc = pc + WIDTH'(1);

    // Next-state selection: stall freezes everything, then jump, then increment.
    always_comb begin
        pc_next    = pc;
        taken_next = 1'b0;
        count_next = jump_count;
        if (stall) begin
            pc_next    = pc;
            taken_next = 1'b0;
            count_next = jump_count;
        end else if (jump) begin
            pc_next    = a_in;
            taken_next = 1'b1;
            if (jump_count != {CNT_WIDTH{1'b1}}) begin
                count_next = jump_count + CNT_WIDTH'(1);
            end
        end else begin
            pc_next    = pc_inc;
            taken_next = 1'b0;
        end
    end

    // State registers; reset forces the vector and clears the jump reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_VECTOR;
            jump_taken <= 1'b0;
            jump_count <= '0;
        end else begin
            pc         <= pc_next;
            jump_taken <= taken_next;
            jump_count <= count_next;
        end
    end

endmodule

// File: tb/tb_pc_jump_n2t.sv
// Scoreboard bench for pc_jump_n2t: stimulus pushes the expected post-edge
// state into a queue, a monitor pops and compares it after every rising edge.
module tb_pc_jump_n2t;

    localparam int WIDTH     = 15;
    localparam int CNT_WIDTH = 8;
    localparam int PC_MOD    = 1 << WIDTH;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    typedef struct {
        int pc;
        int taken;
        int count;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 stall;
    logic                 is_c_instr;
    logic [2:0]           jbits;
    logic                 zr;
    logic                 ng;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     pc;
    logic                 jump_taken;
    logic [CNT_WIDTH-1:0] jump_count;

    exp_t sb[$];
    exp_t mon_e;

    int m_pc;
    int m_taken;
    int m_count;

    int errors = 0;
    int checks = 0;

    pc_jump_n2t #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (15'h0000),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .is_c_instr (is_c_instr),
        .jbits      (jbits),
        .zr         (zr),
        .ng         (ng),
        .a_in       (a_in),
        .pc         (pc),
        .jump_taken (jump_taken),
        .jump_count (jump_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural reference: the ALU result sign described by the flags picks
    // which jump bits matter, evaluated exactly as the Hack jump rule states.
    function automatic bit model_jump(input bit isc, input bit [2:0] jb, input bit z, input bit n);
        bit lt, eq, gt;
        lt = n;
        eq = z;
        gt = !n && !z;
        return isc && ((jb[2] && lt) || (jb[1] && eq) || (jb[0] && gt));
    endfunction

    // Called at a falling edge: drive inputs, predict state after next rising edge.
    task automatic applyStimulus(input bit st, input bit isc, input bit [2:0] jb,
                                 input bit z, input bit n, input int a);
        exp_t e;
        stall      = st;
        is_c_instr = isc;
        jbits      = jb;
        zr         = z;
        ng         = n;
        a_in       = WIDTH'(a);
        if (st) begin
            m_taken = 0;
        end else if (model_jump(isc, jb, z, n)) begin
            m_pc    = a % PC_MOD;
            m_taken = 1;
            m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
        end else begin
            m_pc    = (m_pc + 1) % PC_MOD;
            m_taken = 0;
        end
        e.pc    = m_pc;
        e.taken = m_taken;
        e.count = m_count;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Called at a falling edge: pulse reset between edges and check it acts at once.
    task automatic pulseReset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        check_val({tag, " pc"}, int'(pc), 0);
        check_val({tag, " jump_taken"}, int'(jump_taken), 0);
        check_val({tag, " jump_count"}, int'(jump_count), 0);
        m_pc    = 0;
        m_taken = 0;
        m_count = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: outputs change only on rising edges, so compare shortly after one.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_val("pc", int'(pc), mon_e.pc);
                check_val("jump_taken", int'(jump_taken), mon_e.taken);
                check_val("jump_count", int'(jump_count), mon_e.count);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        is_c_instr = 1'b0;
        jbits      = 3'b000;
        zr         = 1'b0;
        ng         = 1'b0;
        a_in       = '0;
        m_pc       = 0;
        m_taken    = 0;
        m_count    = 0;

        #2;
        check_val("power-on pc", int'(pc), 0);
        check_val("power-on jump_count", int'(jump_count), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reach pc=0x0123 via a jump, then reset mid-run.
        applyStimulus(0, 1, 3'b111, 0, 0, 'h0123);
        pulseReset("mid-run reset");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3'b000, 0, 0, 'h0055);
        check_val("pc after 3 increments", int'(pc), 3);

        // Conditional jumps toward 0x0040.
        applyStimulus(0, 1, 3'b001, 0, 0, 'h0040);   // JGT, positive: taken
        applyStimulus(0, 1, 3'b001, 1, 0, 'h0040);   // JGT, zero: not taken
        applyStimulus(0, 1, 3'b110, 0, 1, 'h0040);   // JLE, negative: taken
        applyStimulus(0, 1, 3'b101, 1, 0, 'h0040);   // JNE, zero: not taken

        // A-instruction with all jump bits set must not branch.
        applyStimulus(0, 0, 3'b111, 0, 0, 'h0100);
        applyStimulus(0, 0, 3'b111, 1, 1, 'h0100);

        // Stall while JMP is presented, then release.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 3'b111, 0, 0, 'h0200);
        applyStimulus(0, 1, 3'b111, 0, 0, 'h0200);

        // Wrap: load the top address, then increment.
        applyStimulus(0, 1, 3'b111, 0, 0, 'h7FFF);
        applyStimulus(0, 0, 3'b000, 0, 0, 'h0000);
        check_val("pc wrap", int'(pc), 0);

        // Tight JMP loop to a fixed target until the counter saturates.
        for (int i = 0; i < 300; i++) applyStimulus(0, 1, 3'b111, 0, 0, 'h0010);
        check_val("saturated count", int'(jump_count), CNT_MAX);
        pulseReset("reset after saturation");

        // Random traffic, including the illegal zr&ng flags and stalls.
        for (int i = 0; i < 600; i++) begin
            bit st;
            int a;
            st = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 3) == 0) ? m_pc : int'($urandom_range(0, PC_MOD - 1));
            applyStimulus(st, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
        end

        // Stall during reset: reset must still win.
        stall = 1'b1;
        pulseReset("reset during stall");
        applyStimulus(0, 0, 3'b000, 0, 0, 0);

        check_val("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
